// File: rtl/bip_per_bus_arbiter_if.sv
// Requester-side handshake bundle for bip_per_bus_arbiter.
// master: driven by the two requesters (M0 = CPU Mem_IO port, M1 = debug/loader).
// slave : seen by the arbiter.
interface bip_per_bus_arbiter_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10
) ();
    logic                  i_req_m0;
    logic                  i_wr_m0;
    logic [ADDR_WIDTH-1:0] i_addr_m0;
    logic [DATA_WIDTH-1:0] i_wdata_m0;
    logic                  o_ack_m0;
    logic [DATA_WIDTH-1:0] o_rdata_m0;

    logic                  i_req_m1;
    logic                  i_wr_m1;
    logic [ADDR_WIDTH-1:0] i_addr_m1;
    logic [DATA_WIDTH-1:0] i_wdata_m1;
    logic                  o_ack_m1;
    logic [DATA_WIDTH-1:0] o_rdata_m1;

    logic                  o_err;

    modport master (
        output i_req_m0, i_wr_m0, i_addr_m0, i_wdata_m0,
        output i_req_m1, i_wr_m1, i_addr_m1, i_wdata_m1,
        input  o_ack_m0, o_rdata_m0, o_ack_m1, o_rdata_m1, o_err
    );

    modport slave (
        input  i_req_m0, i_wr_m0, i_addr_m0, i_wdata_m0,
        input  i_req_m1, i_wr_m1, i_addr_m1, i_wdata_m1,
        output o_ack_m0, o_rdata_m0, o_ack_m1, o_rdata_m1, o_err
    );
endinterface

// File: rtl/bip_per_bus_arbiter.sv
// bip_per_bus_arbiter: round-robin sharing of the BIP peripheral bus between
// two single-word requesters, sequencing IDLE -> ACCESS -> DONE per transaction.
// Optional macro BIP_PER_TIMEOUT_EN: abort ACCESS after TIMEOUT_CYCLES without
// ready, acking with o_err=1 and all-ones read data.
//
//   state  | meaning
//   IDLE   | bus released; arbitrate and latch the winner's request
//   ACCESS | cs asserted, bus driven on writes; wait for WAIT_STATES and ready
//   DONE   | bus released; one-cycle ack to the served master; flip priority
module bip_per_bus_arbiter #(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 10,
    parameter int WAIT_STATES    = 1,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    bip_per_bus_arbiter_if.slave   req_if,
    output logic [ADDR_WIDTH-1:0]  o_addr_bus_per,
    output logic                   o_cs_perif,
    output logic                   o_w_r_per,
    input  logic                   i_per_ready,
    inout  wire  [DATA_WIDTH-1:0]  io_per_data_bus
);
    // The counter only has to reach the larger of the two thresholds; it saturates there.
    localparam int CNT_MAX = (TIMEOUT_CYCLES > WAIT_STATES) ? TIMEOUT_CYCLES : WAIT_STATES;
    localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_ptr;
    logic                  r_gnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_cs;
    logic                  r_w_r;
    logic                  r_ack_m0;
    logic                  r_ack_m1;
    logic [DATA_WIDTH-1:0] r_rdata_m0;
    logic [DATA_WIDTH-1:0] r_rdata_m1;

    logic                  w_gnt_m1;
    logic                  w_ws_met;
    logic [DATA_WIDTH-1:0] w_rd_cap;

    // r_ptr = 1 gives M1 priority when both request.
    assign w_gnt_m1 = req_if.i_req_m1 & (~req_if.i_req_m0 | r_ptr);
    assign w_ws_met = $signed(32'(r_cnt)) >= WAIT_STATES;
    assign w_rd_cap = r_w_r ? '0 : io_per_data_bus;

`ifdef BIP_PER_TIMEOUT_EN
    logic r_err;
    logic w_timeout;
    // Last ACCESS cycle before the counter would reach TIMEOUT_CYCLES.
    assign w_timeout  = $signed(32'(r_cnt)) == (TIMEOUT_CYCLES - 1);
    assign req_if.o_err = r_err;
`else
    assign req_if.o_err = 1'b0;
`endif

    assign o_cs_perif        = r_cs;
    assign o_w_r_per         = r_w_r;
    assign o_addr_bus_per    = r_addr;
    assign io_per_data_bus   = (r_cs && r_w_r) ? r_wdata : 'z;
    assign req_if.o_ack_m0   = r_ack_m0;
    assign req_if.o_ack_m1   = r_ack_m1;
    assign req_if.o_rdata_m0 = r_rdata_m0;
    assign req_if.o_rdata_m1 = r_rdata_m1;

    // Transaction sequencer: arbitration, bus strobes, wait counting and ack generation.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state    <= S_IDLE;
            r_ptr      <= 1'b0;
            r_gnt      <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_cnt      <= '0;
            r_cs       <= 1'b0;
            r_w_r      <= 1'b0;
            r_ack_m0   <= 1'b0;
            r_ack_m1   <= 1'b0;
            r_rdata_m0 <= '0;
            r_rdata_m1 <= '0;
`ifdef BIP_PER_TIMEOUT_EN
            r_err      <= 1'b0;
`endif
        end else begin
            // Ack, read data and error are single-cycle; they only live in DONE.
            r_ack_m0   <= 1'b0;
            r_ack_m1   <= 1'b0;
            r_rdata_m0 <= '0;
            r_rdata_m1 <= '0;
`ifdef BIP_PER_TIMEOUT_EN
            r_err      <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (req_if.i_req_m0 || req_if.i_req_m1) begin
                        r_gnt   <= w_gnt_m1;
                        r_w_r   <= w_gnt_m1 ? req_if.i_wr_m1    : req_if.i_wr_m0;
                        r_addr  <= w_gnt_m1 ? req_if.i_addr_m1  : req_if.i_addr_m0;
                        r_wdata <= w_gnt_m1 ? req_if.i_wdata_m1 : req_if.i_wdata_m0;
                        r_cs    <= 1'b1;
                        r_state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (w_ws_met && i_per_ready) begin
                        r_cs    <= 1'b0;
                        r_w_r   <= 1'b0;
                        r_state <= S_DONE;
                        if (r_gnt) begin
                            r_ack_m1   <= 1'b1;
                            r_rdata_m1 <= w_rd_cap;
                        end else begin
                            r_ack_m0   <= 1'b1;
                            r_rdata_m0 <= w_rd_cap;
                        end
                    end
`ifdef BIP_PER_TIMEOUT_EN
                    else if (w_timeout) begin
                        r_cs    <= 1'b0;
                        r_w_r   <= 1'b0;
                        r_err   <= 1'b1;
                        r_state <= S_DONE;
                        if (r_gnt) begin
                            r_ack_m1   <= 1'b1;
                            r_rdata_m1 <= '1;
                        end else begin
                            r_ack_m0   <= 1'b1;
                            r_rdata_m0 <= '1;
                        end
                    end
`endif
                    else if (r_cnt != CNT_W'(CNT_MAX)) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    r_ptr   <= ~r_gnt;
                    r_cnt   <= '0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_cs    <= 1'b0;
                    r_w_r   <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
